// File: rtl/tile_move_checker.sv
// rtl/tile_move_checker.sv - per-tick Pacman move arbiter against a registered maze wall ROM
module tile_move_checker #(
    parameter logic [4:0] START_X = 5'd1,
    parameter logic [4:0] START_Y = 5'd1,
    parameter int         COLS    = 32,
    parameter int         ROWS    = 24
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       tick,
    input  logic [2:0] dir_req,
    output logic [9:0] maze_addr,
    input  logic       maze_wall,
    output logic [4:0] x_tile,
    output logic [4:0] y_tile,
    output logic [2:0] dir_out,
    output logic       go,
    output logic       blocked,
    output logic       busy
);

    localparam logic [2:0] DIR_RIGHT = 3'b000;
    localparam logic [2:0] DIR_UP    = 3'b001;
    localparam logic [2:0] DIR_LEFT  = 3'b010;
    localparam logic [2:0] DIR_DOWN  = 3'b011;
    localparam logic [2:0] DIR_WAIT  = 3'b100;

    typedef enum logic [2:0] {IDLE, LOOK_REQ, EVAL_REQ, LOOK_CUR, EVAL_CUR, COMMIT} state_t;
    // COMMIT doubles as the single pulse cycle; outcome says which pulse (if any) it carries
    typedef enum logic [1:0] {OUT_NONE, OUT_MOVE, OUT_BLOCK} outcome_t;

    typedef struct packed {
        logic       ok;
        logic [4:0] x;
        logic [4:0] y;
    } target_t;

    // Neighbour tile in direction d; ok=0 for wait codes and for leaving the grid vertically
    function automatic target_t target_of(input logic [2:0] d, input logic [4:0] x, input logic [4:0] y);
        target_t t;
        t.ok = 1'b1;
        t.x  = x;
        t.y  = y;
        case (d)
            DIR_RIGHT: t.x = (x == 5'(COLS - 1)) ? 5'd0 : x + 5'd1;
            DIR_LEFT:  t.x = (x == 5'd0) ? 5'(COLS - 1) : x - 5'd1;
            DIR_UP:    if (y == 5'd0) t.ok = 1'b0; else t.y = y - 5'd1;
            DIR_DOWN:  if (y == 5'(ROWS - 1)) t.ok = 1'b0; else t.y = y + 5'd1;
            default:   t.ok = 1'b0;
        endcase
        return t;
    endfunction

    state_t     state, state_n;
    outcome_t   outcome, outcome_n;
    logic [2:0] req_r, req_n;
    logic [4:0] cand_x, cand_y, cand_x_n, cand_y_n;
    logic [2:0] cand_dir, cand_dir_n;
    logic [9:0] addr_n;
    logic       commit_ld;
    logic [2:0] req_in, fb_req;
    target_t    req_t, cur_t;

    assign req_in = (dir_req > DIR_WAIT) ? DIR_WAIT : dir_req;
    assign fb_req = (state == IDLE) ? req_in : req_r;
    assign req_t  = target_of(req_in, x_tile, y_tile);
    assign cur_t  = target_of(dir_out, x_tile, y_tile);

    assign go      = (state == COMMIT) && (outcome == OUT_MOVE);
    assign blocked = (state == COMMIT) && (outcome == OUT_BLOCK);
    assign busy    = (state != IDLE);

    // Next-state logic; the fallback decision is shared by the IDLE tick and a walled request
    always_comb begin
        state_n    = state;
        outcome_n  = outcome;
        req_n      = req_r;
        cand_x_n   = cand_x;
        cand_y_n   = cand_y;
        cand_dir_n = cand_dir;
        addr_n     = maze_addr;
        commit_ld  = 1'b0;
        case (state)
            IDLE: begin
                if (tick) begin
                    req_n = req_in;
                    if (req_t.ok) begin
                        state_n    = LOOK_REQ;
                        addr_n     = {req_t.y, req_t.x};
                        cand_x_n   = req_t.x;
                        cand_y_n   = req_t.y;
                        cand_dir_n = req_in;
                    end else if (cur_t.ok && dir_out != fb_req) begin
                        state_n    = LOOK_CUR;
                        addr_n     = {cur_t.y, cur_t.x};
                        cand_x_n   = cur_t.x;
                        cand_y_n   = cur_t.y;
                        cand_dir_n = dir_out;
                    end else begin
                        state_n   = COMMIT;
                        outcome_n = (fb_req == DIR_WAIT && dir_out == DIR_WAIT) ? OUT_NONE : OUT_BLOCK;
                    end
                end
            end
            LOOK_REQ: state_n = EVAL_REQ;
            EVAL_REQ: begin
                if (!maze_wall) begin
                    state_n   = COMMIT;
                    outcome_n = OUT_MOVE;
                    commit_ld = 1'b1;
                end else if (cur_t.ok && dir_out != fb_req) begin
                    state_n    = LOOK_CUR;
                    addr_n     = {cur_t.y, cur_t.x};
                    cand_x_n   = cur_t.x;
                    cand_y_n   = cur_t.y;
                    cand_dir_n = dir_out;
                end else begin
                    state_n   = COMMIT;
                    outcome_n = OUT_BLOCK;
                end
            end
            LOOK_CUR: state_n = EVAL_CUR;
            EVAL_CUR: begin
                state_n   = COMMIT;
                outcome_n = maze_wall ? OUT_BLOCK : OUT_MOVE;
                commit_ld = !maze_wall;
            end
            COMMIT:   state_n = IDLE;
            default:  state_n = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end

    // Datapath registers; accepted position changes on the edge entering COMMIT so it lines up with go
    always_ff @(posedge clock) begin
        if (reset) begin
            outcome   <= OUT_NONE;
            req_r     <= DIR_WAIT;
            cand_x    <= START_X;
            cand_y    <= START_Y;
            cand_dir  <= DIR_WAIT;
            maze_addr <= 10'd0;
            x_tile    <= START_X;
            y_tile    <= START_Y;
            dir_out   <= DIR_WAIT;
        end else begin
            outcome   <= outcome_n;
            req_r     <= req_n;
            cand_x    <= cand_x_n;
            cand_y    <= cand_y_n;
            cand_dir  <= cand_dir_n;
            maze_addr <= addr_n;
            if (commit_ld) begin
                x_tile  <= cand_x;
                y_tile  <= cand_y;
                dir_out <= cand_dir;
            end
        end
    end

endmodule
